// File: rtl/bicubic_pkg.sv
// Shared constants for the bicubic vertical tap MAC.
// Holds default widths, the sum guard width and helpers that derive the
// rounding constant and accumulator width from the module parameters.
package bicubic_pkg;

    localparam int unsigned PIX_W_DEF  = 8;
    localparam int unsigned COEF_W_DEF = 17;
    localparam int unsigned WFRAC_DEF  = 14;

    // Two guard bits cover the growth of a four-term sum.
    localparam int unsigned SUM_GUARD  = 2;

    // Width of one pixel x weight product: unsigned pixel gains a sign bit.
    function automatic int unsigned prod_width(int unsigned pix_w, int unsigned coef_w);
        return pix_w + coef_w + 1;
    endfunction

    function automatic int unsigned sum_width(int unsigned pix_w, int unsigned coef_w);
        return prod_width(pix_w, coef_w) + SUM_GUARD;
    endfunction

    // Half an output LSB, added before the truncating shift.
    function automatic int unsigned round_const(int unsigned wfrac);
        return 1 << (wfrac - 1);
    endfunction

    localparam int unsigned SUM_W_DEF   = sum_width(PIX_W_DEF, COEF_W_DEF);
    localparam int unsigned ROUND_C_DEF = round_const(WFRAC_DEF);

endpackage

// File: rtl/bicubic_tap_mul.sv
// Registered signed multiplier: unsigned pixel times two's-complement weight.
// Ports:
//   clk  - rising-edge clock
//   en   - pipeline enable; product register holds while low
//   pix  - unsigned pixel, PIX_W bits
//   coef - signed weight, COEF_W bits
//   prod - registered signed product, PIX_W+COEF_W+1 bits
module bicubic_tap_mul
    import bicubic_pkg::*;
#(
    parameter int unsigned PIX_W  = PIX_W_DEF,
    parameter int unsigned COEF_W = COEF_W_DEF
) (
    input  logic                      clk,
    input  logic                      en,
    input  logic [PIX_W-1:0]          pix,
    input  logic [COEF_W-1:0]         coef,
    output logic [PIX_W+COEF_W:0]     prod
);

    localparam int unsigned PROD_W = PIX_W + COEF_W + 1;

    logic signed [PIX_W:0]    pix_s;
    logic signed [COEF_W-1:0] coef_s;
    logic signed [PROD_W-1:0] prod_d;
    logic signed [PROD_W-1:0] prod_q;

    // Zero-extend so the pixel is treated as non-negative in a signed multiply.
    assign pix_s  = {1'b0, pix};
    assign coef_s = coef;
    assign prod_d = pix_s * coef_s;

    always_ff @(posedge clk) begin
        if (en) begin
            prod_q <= prod_d;
        end
    end

    assign prod = prod_q;

endmodule

// File: rtl/bicubic_tap_mac.sv
// Four-tap vertical bicubic multiply-accumulate with valid/ready handshakes.
// Pipeline: S1 products, S2 four-term sum, S3 round-half-up + clamp to pixel.
// All stages advance on en = !out_valid || out_ready; in_ready = en.
// Optional feature: define BICUBIC_TAP_SAT_CNT_EN to count clamped outputs
// in sat_cnt (saturating at 16'hFFFF); otherwise sat_cnt is tied to zero.
// Ports:
//   clk, rst_n        - clock, synchronous active-low reset
//   in_valid/in_ready - input handshake
//   pix0..pix3        - unsigned pixels, top to bottom
//   bi_y0..bi_y3      - signed weights paired with pix0..pix3
//   out_valid/out_ready, out_pix - output handshake and interpolated pixel
//   sat_cnt           - clamp event counter
module bicubic_tap_mac
    import bicubic_pkg::*;
#(
    parameter int unsigned PIX_W  = PIX_W_DEF,
    parameter int unsigned COEF_W = COEF_W_DEF,
    parameter int unsigned WFRAC  = WFRAC_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PIX_W-1:0]  pix0,
    input  logic [PIX_W-1:0]  pix1,
    input  logic [PIX_W-1:0]  pix2,
    input  logic [PIX_W-1:0]  pix3,
    input  logic [COEF_W-1:0] bi_y0,
    input  logic [COEF_W-1:0] bi_y1,
    input  logic [COEF_W-1:0] bi_y2,
    input  logic [COEF_W-1:0] bi_y3,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PIX_W-1:0]  out_pix,
    output logic [15:0]       sat_cnt
);

    localparam int unsigned PROD_W = prod_width(PIX_W, COEF_W);
    localparam int unsigned SUM_W  = sum_width(PIX_W, COEF_W);
    // One extra bit so adding the rounding constant cannot overflow.
    localparam int unsigned RND_W  = SUM_W + 1;

    localparam logic signed [RND_W-1:0] ROUND_K = RND_W'(round_const(WFRAC));
    localparam logic signed [RND_W-1:0] PIX_MAX = {{(RND_W - PIX_W){1'b0}}, {PIX_W{1'b1}}};

    logic en;
    logic take;
    logic v1_q, v2_q, v3_q;

    logic [PIX_W-1:0]  pix_a  [4];
    logic [COEF_W-1:0] coef_a [4];
    logic [PROD_W-1:0] prod   [4];

    logic signed [SUM_W-1:0] sum_d, sum_q;
    logic signed [RND_W-1:0] rnd, shifted;
    logic                    under, over;
    logic [PIX_W-1:0]        pix_d, out_pix_q;

    assign en       = !v3_q || out_ready;
    assign take     = in_valid && en;
    assign in_ready = en;

    assign pix_a[0]  = pix0;
    assign pix_a[1]  = pix1;
    assign pix_a[2]  = pix2;
    assign pix_a[3]  = pix3;
    assign coef_a[0] = bi_y0;
    assign coef_a[1] = bi_y1;
    assign coef_a[2] = bi_y2;
    assign coef_a[3] = bi_y3;

    // S1: four registered products.
    for (genvar g = 0; g < 4; g++) begin : g_tap
        bicubic_tap_mul #(
            .PIX_W  (PIX_W),
            .COEF_W (COEF_W)
        ) u_mul (
            .clk  (clk),
            .en   (en),
            .pix  (pix_a[g]),
            .coef (coef_a[g]),
            .prod (prod[g])
        );
    end

    // S2: sign-extended sum of the products.
    always_comb begin
        sum_d = '0;
        for (int i = 0; i < 4; i++) begin
            sum_d = sum_d + SUM_W'($signed(prod[i]));
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            sum_q <= sum_d;
        end
    end

    // S3: round half-up, arithmetic shift, clamp to 0..2^PIX_W-1.
    always_comb begin
        rnd     = {sum_q[SUM_W-1], sum_q} + ROUND_K;
        shifted = rnd >>> WFRAC;
        under   = shifted[RND_W-1];
        over    = !under && (shifted > PIX_MAX);
        pix_d   = '0;
        if (over) begin
            pix_d = '1;
        end else if (!under) begin
            pix_d = shifted[PIX_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            v3_q      <= 1'b0;
            out_pix_q <= '0;
        end else if (en) begin
            v1_q      <= take;
            v2_q      <= v1_q;
            v3_q      <= v2_q;
            out_pix_q <= pix_d;
        end
    end

    assign out_valid = v3_q;
    assign out_pix   = out_pix_q;

`ifdef BICUBIC_TAP_SAT_CNT_EN
    logic        sat_q;
    logic [15:0] sat_cnt_q;

    // Flag travels with the S3 sample; only meaningful while v3_q is set.
    always_ff @(posedge clk) begin
        if (en) begin
            sat_q <= under || over;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sat_cnt_q <= '0;
        end else if (v3_q && out_ready && sat_q && (sat_cnt_q != 16'hFFFF)) begin
            sat_cnt_q <= sat_cnt_q + 16'd1;
        end
    end

    assign sat_cnt = sat_cnt_q;
`else
    assign sat_cnt = '0;
`endif

endmodule

// File: doc/bicubic_tap_mac.md
BICUBIC_TAP_MAC -- requirements
Module: bicubic_tap_mac

Interface
- REQ-001 SHALL have parameter PIX_W, default 8, unsigned pixel width.
- REQ-002 SHALL have parameter COEF_W, default 17, width of each two's-complement kernel weight.
- REQ-003 SHALL have parameter WFRAC, default 14, number of fractional bits in a weight (1.0 = 2^WFRAC).
- REQ-004 SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge.
- REQ-005 SHALL have port rst_n, input, 1 bit, reset that is synchronous and active-low.
- REQ-006 SHALL have port in_valid, input, 1 bit, tap set is present on the input.
- REQ-007 SHALL have port in_ready, output, 1 bit, block accepts the tap set this cycle.
- REQ-008 SHALL have ports pix0..pix3, input, PIX_W bits each, four vertically adjacent pixels, top to bottom.
- REQ-009 SHALL have ports bi_y0..bi_y3, input, COEF_W bits each, signed weights paired with pix0..pix3.
- REQ-010 SHALL have port out_valid, output, 1 bit, the result is valid.
- REQ-011 SHALL have port out_ready, input, 1 bit, the downstream consumer accepts the result.
- REQ-012 SHALL have port out_pix, output, PIX_W bits, the interpolated pixel.
- REQ-013 SHALL have port sat_cnt, output, 16 bits, the clamp event counter (see Configuration).

Function
- REQ-014 SHALL transfer an input when in_valid and in_ready are both 1 in the same cycle.
- REQ-015 SHALL transfer an output when out_valid and out_ready are both 1 in the same cycle.
- REQ-016 SHALL use a 3-stage pipeline: S1 registers pixel×weight products (PIX_W+COEF_W+1 signed bits); S2 registers the 4-product sum (2 guard bits); S3 registers the rounded, clamped out_pix.
- REQ-017 SHALL present a result on out_valid/out_pix exactly 3 cycles after its input handshake when out_ready is held at 1.
- REQ-018 SHALL advance all stages on a common enable, en = !out_valid || out_ready, and drive in_ready = en.
- REQ-019 SHALL hold every stage register unchanged while en = 0, so no data is lost or duplicated.
- REQ-020 SHALL track one valid bit per stage and load a bubble (valid 0) when en = 1 and no input is transferred.
- REQ-021 SHALL round half-up: add 2^(WFRAC-1) to the sum, then arithmetic-shift right by WFRAC.
- REQ-022 SHALL clamp the shifted value to the range 0..2^PIX_W-1.
- REQ-023 SHALL, when the clamp alters the value, flag a saturation event for that sample in S3.
- REQ-024 SHALL sustain one sample per cycle when out_ready = 1, with no bubbles inserted.
- REQ-025 SHALL accept a new input and emit an output in the same cycle when in_valid = out_valid = out_ready = 1.

Reset
- REQ-026 SHALL, while rst_n = 0 at a clock edge, clear all stage valid bits and force out_valid = 0, out_pix = 0, sat_cnt = 0.
- REQ-027 SHALL force in_ready = 1 on the first cycle after reset.
- REQ-028 SHALL discard in-flight samples when reset is asserted mid-stream and never emit them afterwards.
- REQ-029 SHALL not reset datapath registers other than out_pix.

Configuration
- REQ-030 SHALL, with macro BICUBIC_TAP_SAT_CNT_EN defined, count in sat_cnt each output handshake whose sample carries a saturation flag.
- REQ-031 SHALL saturate sat_cnt at 16'hFFFF rather than wrapping.
- REQ-032 SHALL, without BICUBIC_TAP_SAT_CNT_EN, tie sat_cnt to 0 and synthesise no counter logic; out_pix behaviour is identical in both builds.

Structure
- REQ-033 SHALL place the defaults for PIX_W, COEF_W and WFRAC, the rounding constant and the sum-width constant in shared package bicubic_pkg.
- REQ-034 SHALL implement one signed unsigned-pixel×weight registered multiplier as sub-module bicubic_tap_mul, instantiated four times.

Verification
- REQ-035 SHALL check identity: weights (0,16384,0,0), pixels (10,200,30,40), out_ready=1 -> out_pix=200 with out_valid exactly 3 cycles later.
- REQ-036 SHALL check rounding: weights (8192,8192,0,0), pixels (1,2,0,0) -> sum 1.5 -> out_pix=2; pixels (1,1,0,0) -> out_pix=1.
- REQ-037 SHALL check overshoot: weights (-2048,10240,10240,-2048), pixels (0,255,255,0) -> out_pix=255, and sat_cnt increments to 1 when the macro is defined, else stays 0.
- REQ-038 SHALL check undershoot: the same weights with pixels (255,0,0,255) -> out_pix=0, and sat_cnt increments when the macro is defined.
- REQ-039 SHALL check backpressure: stream 6 samples while out_ready is held at 0 for 5 cycles mid-stream -> in_ready drops, out_pix holds stable, and all 6 results arrive in order with none lost or duplicated.
- REQ-040 SHALL check reset mid-operation: assert rst_n=0 for 1 cycle with 3 samples in flight -> out_valid=0 next cycle, none of the 3 samples are ever emitted, and in_ready=1.
